npc_ras_unit: RTL
=================

Name: npc_ras_unit

Overview:
- Registered program-counter unit for the single-cycle MIPS core.
- Holds PC and computes the next PC: sequential, branch, jump, register jump, call and return.
- Adds exception/eret redirect, a stall enable, and a parametrised return-address stack (RAS).
- The RAS predicts return targets; the unit flags and counts mispredictions for performance monitoring.
- Architectural correctness never depends on the RAS.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.
- RAS_DEPTH, 4, number of RAS entries (power of two, 2..16).
- CNT_W, 16, width of the misprediction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  synchronous active-low reset.
- en  in  1  PC advance enable; 0 = stall.
- npc_op  in  3  next-PC operation.
- imm  in  26  instruction immediate/target field.
- reg_val  in  32  rs register value.
- exc_req  in  1  exception taken this cycle.
- eret_req  in  1  return from exception.
- epc  in  32  exception return address.
- pc  out  32  current PC (registered).
- npc  out  32  next PC (combinational).
- ras_valid  out  1  RAS non-empty.
- ras_top  out  32  current RAS top entry (0 when empty).
- mispredict  out  1  registered one-cycle pulse.
- mispred_cnt  out  CNT_W  saturating misprediction count.

Behaviour:
- Reset (rstn=0 at a rising edge): pc=RESET_PC, RAS count=0, ras_valid=0, ras_top=0, mispredict=0, mispred_cnt=0. Reset overrides all other inputs, including mid-stall.
- pc4 = pc+4 (mod 2^32).
- npc_op encoding and resulting npc:
  - 000 PLUS4: pc4.
  - 001 BRANCH: pc4 + {{14{imm[15]}}, imm[15:0], 2'b00}.
  - 010 JUMP: {pc4[31:28], imm, 2'b00}.
  - 011 JREG: reg_val.
  - 100 CALL: JUMP target; push pc4.
  - 101 CALLR: reg_val; push pc4.
  - 110 RET: reg_val; pop.
  - 111: treated as PLUS4.
- Redirect priority, highest first:
  - exc_req: npc=EXC_VEC.
  - eret_req: npc=epc.
  - Otherwise npc per npc_op.
- Redirects do not touch the RAS.
- Update rule: pc<=npc when en=1 or exc_req=1. Exceptions are never stalled.
- When en=0 and exc_req=0: pc holds, RAS unchanged, mispredict<=0.
- npc is always driven combinationally, regardless of en.
- RAS push (en=1, no redirect):
  - Write pc4 at the top pointer; pointer increments mod RAS_DEPTH.
  - count = min(count+1, RAS_DEPTH).
  - When full, the oldest entry is overwritten (circular buffer).
- RAS pop (en=1, no redirect):
  - If count>0: compare ras_top to reg_val; pointer decrements, count decrements.
  - If count=0: no pop, no comparison, no mispredict.
- mispredict: registered; 1 on the cycle after a RET whose RAS entry was valid and differed from reg_val, else 0.
- mispred_cnt increments on the same edge mispredict is set, saturating at all-ones.
- ras_top = entry at pointer-1 when count>0, else 0. ras_valid = (count!=0).
- A reserved op or a stalled RET/CALL has no RAS side effect.
- No delay slot; link value is pc+4.

Test Plan:
- Reset, then 3 cycles of PLUS4 with en=1 -> pc = 0x3000, 0x3004, 0x3008, 0x300C; mispredict=0, mispred_cnt=0.
- At pc=0x3010: BRANCH with imm=16'hFFFC -> npc=0x3004. Then JUMP imm=26'h0000C40 -> npc=0x00003100.
- At pc=0x3020: CALL imm=26'h0000C80 -> pc=0x3200, ras_top=0x3024, ras_valid=1. Then RET with reg_val=0x3024 -> pc=0x3024, mispredict stays 0, ras_valid=0. Repeat the RET with reg_val=0x3028 after a fresh CALL -> pc=0x3028, mispredict pulses 1 for one cycle, mispred_cnt=1.
- Overflow: 5 CALLRs with RAS_DEPTH=4 from pcs 0x3000,0x3004,…,0x3010 (reg_val returns to the next pc) -> count=4 and ras_top=0x3014. Four matching pops empty the stack; a fifth RET on the empty stack -> pc=reg_val, no mispredict.
- Stall then exception: en=0 with CALL -> pc and RAS unchanged. Assert exc_req with en=0 -> pc=0x4180. Then eret_req with epc=0x3040 -> pc=0x3040. Assert exc_req and eret_req together -> pc=0x4180.
- Reset mid-operation: assert rstn=0 with RAS holding 3 entries and mispred_cnt=2 -> next edge pc=0x3000, ras_valid=0, ras_top=0, mispred_cnt=0.

Source files
------------

// File: rtl/npc_ras_unit.sv
// rtl/npc_ras_unit.sv - registered PC and next-PC unit with return-address stack
//
// Holds the architectural PC and computes the next PC from npc_op, with
// exception/eret redirects, a stall enable and a circular return-address
// stack that predicts RET targets and counts mispredictions.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   en                 PC advance enable (0 = stall)
//   npc_op[2:0]        next-PC operation
//   imm[25:0]          instruction immediate / jump target field
//   reg_val[31:0]      rs register value (JREG/CALLR/RET target)
//   exc_req, eret_req  exception entry / return redirects
//   epc[31:0]          exception return address
//   pc[31:0]           current PC (registered)
//   npc[31:0]          next PC (combinational)
//   ras_valid          stack non-empty
//   ras_top[31:0]      stack top entry, 0 when empty
//   mispredict         one-cycle pulse after a mispredicted RET
//   mispred_cnt        saturating mispredict count

module npc_ras_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       npc_op,
  input  logic [25:0]      imm,
  input  logic [31:0]      reg_val,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [31:0]      epc,
  output logic [31:0]      pc,
  output logic [31:0]      npc,
  output logic             ras_valid,
  output logic [31:0]      ras_top,
  output logic             mispredict,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JREG   = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_CALLR  = 3'b101;
  localparam logic [2:0] OP_RET    = 3'b110;

  localparam logic [PW:0] CNT_FULL = (PW+1)'(RAS_DEPTH);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] ptr;     // next free slot; top entry lives at ptr-1
  logic [PW:0]   count;

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic        redirect;
  logic        ras_ok;
  logic        do_push;
  logic        do_pop;
  logic        miss;

  assign pc4      = pc + 32'd4;
  assign br_tgt   = pc4 + {{14{imm[15]}}, imm[15:0], 2'b00};
  assign j_tgt    = {pc4[31:28], imm, 2'b00};
  assign redirect = exc_req | eret_req;

  assign ras_valid = (count != '0);
  assign ras_top   = ras_valid ? ras_mem[ptr - PW'(1)] : 32'd0;

  // The stack only moves on an unstalled, unredirected instruction.
  assign ras_ok  = en & ~redirect;
  assign do_push = ras_ok & ((npc_op == OP_CALL) | (npc_op == OP_CALLR));
  // Popping an empty stack is a no-op: no compare, no mispredict.
  assign do_pop  = ras_ok & (npc_op == OP_RET) & ras_valid;
  assign miss    = do_pop & (ras_top != reg_val);

  always_comb begin
    npc = pc4;
    if (exc_req) begin
      npc = EXC_VEC;
    end else if (eret_req) begin
      npc = epc;
    end else begin
      case (npc_op)
        OP_PLUS4:  npc = pc4;
        OP_BRANCH: npc = br_tgt;
        OP_JUMP:   npc = j_tgt;
        OP_JREG:   npc = reg_val;
        OP_CALL:   npc = j_tgt;
        OP_CALLR:  npc = reg_val;
        OP_RET:    npc = reg_val;
        default:   npc = pc4;
      endcase
    end
  end

  // Stack storage carries no reset; entries are only read while count covers them.
  always_ff @(posedge clk) begin
    if (rstn && do_push) begin
      ras_mem[ptr] <= pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      ptr         <= '0;
      count       <= '0;
      mispredict  <= 1'b0;
      mispred_cnt <= '0;
    end else begin
      // Exceptions bypass the stall.
      if (en || exc_req) begin
        pc <= npc;
      end

      if (do_push) begin
        ptr <= ptr + PW'(1);
        // When full the write above overwrites the oldest entry.
        if (count != CNT_FULL) begin
          count <= count + (PW+1)'(1);
        end
      end else if (do_pop) begin
        ptr   <= ptr - PW'(1);
        count <= count - (PW+1)'(1);
      end

      mispredict <= miss;
      if (miss && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      end
    end
  end

endmodule
